// File: rtl/dmem_responder.sv
// Multi-cycle data memory for the load/store path: one request in flight, commit LATENCY edges after accept.
// Response is held until rsp_ready; req_ready stays low from accept until the response handshake.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

    stateT       state, nextState;
    logic [2:0]  cnt;
    logic        capWe, capUnsigned;
    logic [31:0] capAddr, capWdata;
    logic [1:0]  capSize;
    logic        accept, commit, handshake;
    logic        opWe, opUnsigned;
    logic [31:0] opAddr, opWdata;
    logic [1:0]  opSize;
    logic        misaligned, outOfRange, opErr;
    logic [AW-1:0] wordIdx;
    logic [31:0] memWord, loadData, storeData;
    logic [7:0]  selByte;
    logic [15:0] selHalf;
    logic [3:0]  byteEn;
    logic [31:0] rdataQ;
    logic        errQ;
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        commit    = 1'b0;
        handshake = 1'b0;
        req_ready = 1'b0;
        busy      = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        commit    = 1'b1;
                        nextState = RESP;
                    end else begin
                        nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt == 3'd0) begin
                    commit    = 1'b1;
                    nextState = RESP;
                end
            end
            RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    handshake = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= 3'd0;
            capWe       <= 1'b0;
            capAddr     <= 32'd0;
            capWdata    <= 32'd0;
            capSize     <= 2'd0;
            capUnsigned <= 1'b0;
        end else if (accept) begin
            cnt         <= 3'(LATENCY - 1);
            capWe       <= req_we;
            capAddr     <= req_addr;
            capWdata    <= req_wdata;
            capSize     <= req_size;
            capUnsigned <= req_unsigned;
        end else if (state == WAIT && cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
        end
    end

    // Zero-latency commits happen on the accept edge, so the live request is used there.
    always_comb begin
        opWe       = (state == IDLE) ? req_we       : capWe;
        opAddr     = (state == IDLE) ? req_addr     : capAddr;
        opWdata    = (state == IDLE) ? req_wdata    : capWdata;
        opSize     = (state == IDLE) ? req_size     : capSize;
        opUnsigned = (state == IDLE) ? req_unsigned : capUnsigned;
    end

    always_comb begin
        misaligned = (opSize == 2'b11)
                  || (opSize == 2'b01 && opAddr[0])
                  || (opSize == 2'b10 && opAddr[1:0] != 2'b00);
        outOfRange = {2'b00, opAddr[31:2]} >= 32'(DEPTH_WORDS);
        opErr      = misaligned || outOfRange;
        wordIdx    = opAddr[AW+1:2];
        memWord    = mem[wordIdx];
        selByte    = memWord[{opAddr[1:0], 3'b000} +: 8];
        selHalf    = opAddr[1] ? memWord[31:16] : memWord[15:0];
        case (opSize)
            2'b00:   loadData = {{24{selByte[7] & ~opUnsigned}}, selByte};
            2'b01:   loadData = {{16{selHalf[15] & ~opUnsigned}}, selHalf};
            default: loadData = memWord;
        endcase
        case (opSize)
            2'b00: begin
                byteEn    = 4'b0001 << opAddr[1:0];
                storeData = {4{opWdata[7:0]}};
            end
            2'b01: begin
                byteEn    = opAddr[1] ? 4'b1100 : 4'b0011;
                storeData = {2{opWdata[15:0]}};
            end
            default: begin
                byteEn    = 4'b1111;
                storeData = opWdata;
            end
        endcase
    end

    // Array is deliberately left out of reset; reset only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (!reset && commit && opWe && !opErr) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[wordIdx][8*i +: 8] <= storeData[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdataQ <= 32'd0;
            errQ   <= 1'b0;
        end else if (commit) begin
            errQ   <= opErr;
            rdataQ <= (opErr || opWe) ? 32'd0 : loadData;
        end else if (handshake) begin
            rdataQ <= 32'd0;
            errQ   <= 1'b0;
        end
    end

    assign rsp_rdata = rdataQ;
    assign rsp_err   = errQ;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a transaction-level memory model and a per-cycle output compare.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .busy(busy)
    );

    int nChecks = 0;
    int nErrors = 0;
    int cyc = 0;

    // Transaction-level expectation shared with the compare process.
    logic        pending = 1'b0;
    logic        checkEn = 1'b0;
    int          dueCyc  = 0;
    logic [31:0] expRd   = 32'd0;
    logic        expErr  = 1'b0;

    logic [31:0] mdl [DEPTH];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory behaviour as arithmetic on whole words; stores update the model at accept time,
    // which is equivalent because only one request is ever outstanding.
    function automatic void modelOp(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [1:0] size, input logic uns,
                                    output logic [31:0] rd, output logic err);
        int unsigned sh;
        int idx;
        logic [31:0] mask, w, v;
        logic signBit;
        err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0)
           || (longint'(addr) >= longint'(DEPTH) * 4);
        rd = 32'd0;
        if (err) return;
        idx  = int'(addr >> 2);
        sh   = 8 * (addr % 4);
        mask = (size == 2'd0) ? 32'h0000_00FF : (size == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        w    = mdl[idx];
        if (we) begin
            mdl[idx] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
        end else begin
            v = (w >> sh) & mask;
            signBit = (size == 2'd0) ? v[7] : v[15];
            if (!uns && size != 2'd2 && signBit) v = v | ~mask;
            rd = v;
        end
    endfunction

    always @(negedge clk) begin
        if (!reset && checkEn) begin
            logic expV;
            expV = pending && (cyc >= dueCyc);
            check("cmp rsp_valid", {31'd0, rsp_valid}, {31'd0, expV});
            check("cmp req_ready", {31'd0, req_ready}, {31'd0, !pending});
            check("cmp busy", {31'd0, busy}, {31'd0, pending});
            check("cmp rsp_rdata", rsp_rdata, expV ? expRd : 32'd0);
            check("cmp rsp_err", {31'd0, rsp_err}, expV ? {31'd0, expErr} : 32'd0);
        end
    end

    task automatic issue(input string name, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input int stall,
                         input logic [31:0] litRd, input logic litErr);
        logic [31:0] mRd, sRd;
        logic mErr, sErr;
        int waited;
        @(negedge clk);
        check({name, " req_ready before"}, {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        rsp_ready    = (stall == 0);
        @(posedge clk);
        #1;
        modelOp(we, addr, wdata, size, uns, mRd, mErr);
        expRd   = mRd;
        expErr  = mErr;
        dueCyc  = cyc + LAT;
        pending = 1'b1;
        @(negedge clk);
        // Inputs are scrambled while the request is in flight; the captured copy must be used.
        req_valid    = 1'b0;
        req_we       = ~we;
        req_addr     = addr ^ 32'h0000_0014;
        req_wdata    = ~wdata;
        req_size     = ~size;
        req_unsigned = ~uns;
        waited = 0;
        while (!rsp_valid && waited < LAT + 4) begin
            @(negedge clk);
            waited++;
        end
        if (!rsp_valid) begin
            nChecks++;
            nErrors++;
            $display("FAIL %s timeout: rsp_valid never rose, expected within %0d cycles", name, LAT + 4);
            pending = 1'b0;
            rsp_ready = 1'b1;
            return;
        end
        check({name, " rdata"}, rsp_rdata, litRd);
        check({name, " err"}, {31'd0, rsp_err}, {31'd0, litErr});
        sRd  = rsp_rdata;
        sErr = rsp_err;
        repeat (stall) begin
            @(negedge clk);
            check({name, " hold valid"}, {31'd0, rsp_valid}, 32'd1);
            check({name, " hold rdata"}, rsp_rdata, sRd);
            check({name, " hold err"}, {31'd0, rsp_err}, {31'd0, sErr});
            check({name, " hold req_ready"}, {31'd0, req_ready}, 32'd0);
            check({name, " hold busy"}, {31'd0, busy}, 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        pending = 1'b0;
        @(negedge clk);
        check({name, " req_ready after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        rsp_ready    = 1'b1;
        #3;
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset rsp_err", {31'd0, rsp_err}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkEn = 1'b1;

        // Word store/load and sub-word extension on 0xDEADBEEF.
        issue("sw 10", 1, 32'h10, 32'hDEAD_BEEF, 2'd2, 0, 0, 32'h0, 0);
        issue("lw 10", 0, 32'h10, 32'h0, 2'd2, 0, 0, 32'hDEAD_BEEF, 0);
        issue("lb 13", 0, 32'h13, 32'h0, 2'd0, 0, 0, 32'hFFFF_FFDE, 0);
        issue("lbu 13", 0, 32'h13, 32'h0, 2'd0, 1, 0, 32'h0000_00DE, 0);
        issue("lh 10", 0, 32'h10, 32'h0, 2'd1, 0, 0, 32'hFFFF_BEEF, 0);
        issue("lhu 12", 0, 32'h12, 32'h0, 2'd1, 1, 0, 32'h0000_DEAD, 0);
        issue("lbu 10", 0, 32'h10, 32'h0, 2'd0, 1, 0, 32'h0000_00EF, 0);

        // Byte-lane stores; upper wdata bits must be ignored.
        issue("sb 11", 1, 32'h11, 32'hAABB_CC55, 2'd0, 0, 0, 32'h0, 0);
        issue("lw after sb", 0, 32'h10, 32'h0, 2'd2, 0, 0, 32'hDEAD_55EF, 0);
        issue("sh 12", 1, 32'h12, 32'h9999_1234, 2'd1, 0, 0, 32'h0, 0);
        issue("lw after sh", 0, 32'h10, 32'h0, 2'd2, 0, 0, 32'h1234_55EF, 0);
        issue("lb 11", 0, 32'h11, 32'h0, 2'd0, 0, 0, 32'h0000_0055, 0);

        // Error cases against a known word 0; none may write.
        issue("sw 0", 1, 32'h0, 32'h1122_3344, 2'd2, 0, 0, 32'h0, 0);
        issue("err sh 01", 1, 32'h1, 32'hFFFF_FFFF, 2'd1, 0, 0, 32'h0, 1);
        issue("err sw 02", 1, 32'h2, 32'hFFFF_FFFF, 2'd2, 0, 0, 32'h0, 1);
        issue("err size3", 1, 32'h0, 32'hFFFF_FFFF, 2'd3, 0, 0, 32'h0, 1);
        issue("err range", 1, 32'(DEPTH * 4), 32'hFFFF_FFFF, 2'd2, 0, 0, 32'h0, 1);
        issue("err lw 02", 0, 32'h2, 32'h0, 2'd2, 0, 0, 32'h0, 1);
        issue("err lh 03", 0, 32'h3, 32'h0, 2'd1, 1, 0, 32'h0, 1);
        issue("lw 0 intact", 0, 32'h0, 32'h0, 2'd2, 0, 0, 32'h1122_3344, 0);

        // Back-pressure: response held for 5 cycles.
        issue("bp lw 10", 0, 32'h10, 32'h0, 2'd2, 0, 5, 32'h1234_55EF, 0);
        issue("bp err", 1, 32'h6, 32'h0, 2'd2, 0, 3, 32'h0, 1);

        // Reset in WAIT discards a pending store.
        issue("sw 20 zero", 1, 32'h20, 32'h0, 2'd2, 0, 0, 32'h0, 0);
        checkEn = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hA5A5_A5A5;
        req_size  = 2'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("mid-wait busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst req_ready", {31'd0, req_ready}, 32'd1);
        check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'd0);
        check("rst rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkEn = 1'b1;
        issue("lw 20 after rst", 0, 32'h20, 32'h0, 2'd2, 0, 0, 32'h0, 0);
        issue("lw 10 after rst", 0, 32'h10, 32'h0, 2'd2, 0, 0, 32'h1234_55EF, 0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
